// File: rtl/branch_pred_ctrl.sv
// Fetch-side branch predictor and mispredict redirect/flush controller.
// A direct-mapped table of 2-bit saturating counters gives fetch its
// prediction. EX-resolved branches train the table. A misprediction produces
// a one-cycle redirect followed by a FLUSH_CYC-cycle flush window.
// Optional feature macro: BRANCH_PRED_STATS_EN enables the branch and
// mispredict statistics counters. When it is undefined, both ports read 0.
module branch_pred_ctrl #(
  parameter int ENTRIES   = 16,
  parameter int IDX_W     = $clog2(ENTRIES),
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_br_op,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state;
  logic [2:0]  fcnt;
  logic [1:0]  ctr [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_cond;
  logic             is_jal;
  logic             resolve;
  logic             actual;
  logic             mispred;
  logic [31:0]      correct_pc;
  logic             unused_fpc;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign f_idx      = f_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign unused_fpc = ^{f_pc[31:IDX_W+2], f_pc[1:0]};

  // Fetch-side prediction. This reads the current (pre-edge) counter value.
  assign pred_taken = f_valid & ctr[f_idx][1];

  // Decode the EX opcode into conditional, JAL, or non-branch.
  always_comb begin
    is_cond = 1'b0;
    case (ex_br_op)
      5'b01000, 5'b01001, 5'b01100,
      5'b01101, 5'b01110, 5'b01111: is_cond = 1'b1;
      default:                      is_cond = 1'b0;
    endcase
  end

  assign is_jal     = (ex_br_op == 5'b11111);
  // EX inputs seen while flushing belong to the wrong path.
  assign resolve    = ex_valid & (state == IDLE);
  assign actual     = is_cond ? ex_taken : is_jal;
  assign mispred    = resolve & (actual != ex_pred_taken);
  assign correct_pc = actual ? ex_target : (ex_pc + 32'd4);

  // Counter table training. Only conditional branches move a counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (resolve && is_cond) begin
      ctr[ex_idx] <= ex_taken ? ctr_inc(ctr[ex_idx]) : ctr_dec(ctr[ex_idx]);
    end
  end

  // Redirect/flush FSM. All of its outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fcnt        <= 3'd0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      flush       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          redirect <= 1'b0;
          if (mispred) begin
            state       <= FLUSH;
            fcnt        <= 3'(FLUSH_CYC - 1);
            redirect    <= 1'b1;
            redirect_pc <= correct_pc;
            flush       <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FLUSH: begin
          redirect <= 1'b0;
          if (fcnt == 3'd0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        default: begin
          state    <= IDLE;
          redirect <= 1'b0;
          flush    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  function automatic logic [31:0] stat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating statistics counters, advanced on resolve events only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (resolve && (is_cond || is_jal)) branch_cnt <= stat_inc(branch_cnt);
      if (mispred) mispred_cnt <= stat_inc(mispred_cnt);
    end
  end
`else
  assign branch_cnt  = 32'd0;
  assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl. A behavioural model predicts the
// counter table, the flush windows, and the redirect targets. A separate
// monitor pops each expected redirect when the DUT strobes one.
module tb_branch_pred_ctrl;
  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_br_op;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_pred_ctrl #(.ENTRIES(16), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc(f_pc),
    .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_br_op(ex_br_op), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_target(ex_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] rq[$];
  int          mctr[16];
  int          blocked;
  int unsigned mb, mm;
  int          run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_pred(input logic [31:0] pc);
    return mctr[(pc >> 2) % 16] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mctr[i] = 1;
    blocked = 0;
    mb = 0;
    mm = 0;
    rq.delete();
  endtask

  // Reference behaviour for one clock edge, using the inputs now applied.
  task automatic model_edge();
    bit cond, jal, act;
    int idx;
    if (blocked > 0) begin
      blocked--;
    end else if (ex_valid) begin
      cond = (ex_br_op inside {5'b01000, 5'b01001, 5'b01100, 5'b01101, 5'b01110, 5'b01111});
      jal  = (ex_br_op == 5'b11111);
      act  = cond ? ex_taken : jal;
      idx  = (ex_pc >> 2) % 16;
      if (cond) mctr[idx] = ex_taken ? ((mctr[idx] == 3) ? 3 : mctr[idx] + 1)
                                     : ((mctr[idx] == 0) ? 0 : mctr[idx] - 1);
      if (cond || jal) mb++;
      if (act != ex_pred_taken) begin
        mm++;
        rq.push_back(act ? ex_target : ex_pc + 32'd4);
        blocked = FLUSH_CYC;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, f_valid && model_pred(f_pc)});
    chk("busy", {31'd0, busy}, {31'd0, blocked > 0});
    chk("flush", {31'd0, flush}, {31'd0, blocked > 0});
`ifdef BRANCH_PRED_STATS_EN
    chk("branch_cnt", branch_cnt, mb);
    chk("mispred_cnt", mispred_cnt, mm);
`else
    chk("branch_cnt", branch_cnt, 32'd0);
    chk("mispred_cnt", mispred_cnt, 32'd0);
`endif
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic fv, input logic [31:0] fpc, input logic ev,
                     input logic [31:0] epc, input logic [4:0] op, input logic tk,
                     input logic pt, input logic [31:0] tgt);
    f_valid = fv; f_pc = fpc; ex_valid = ev; ex_pc = epc;
    ex_br_op = op; ex_taken = tk; ex_pred_taken = pt; ex_target = tgt;
    tick();
  endtask

  task automatic idle(input logic [31:0] fpc, input int n);
    for (int i = 0; i < n; i++) drv(1'b1, fpc, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // One resolve at pc followed by enough quiet cycles to clear any flush.
  task automatic res(input logic [31:0] pc, input logic [4:0] op, input logic tk,
                     input logic pt, input logic [31:0] tgt);
    drv(1'b1, pc, 1'b1, pc, op, tk, pt, tgt);
    idle(pc, FLUSH_CYC + 1);
  endtask

  // Redirect monitor and flush-window length checker.
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect) begin
        chk("redirect_with_flush", {31'd0, flush}, 32'd1);
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
        end else begin
          chk("redirect_pc", redirect_pc, rq.pop_front());
        end
      end
      if (flush) run++;
      else if (run > 0) begin
        chk("flush_len", run, FLUSH_CYC);
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    rst_n = 1'b0;
    f_valid = 1'b1; f_pc = 32'h40; ex_valid = 1'b0; ex_pc = 32'd0;
    ex_br_op = 5'd0; ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_target = 32'd0;
    model_reset();
    #12;
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Every entry starts weakly not-taken.
    for (int i = 0; i < 16; i++) idle(32'(i * 4), 1);

    // BEQ mispredicted as not-taken, then the entry predicts taken.
    res(32'h40, 5'b01000, 1'b1, 1'b0, 32'h80);
    idle(32'h40, 1);
    chk("beq_trained", {31'd0, pred_taken}, 32'd1);

    // Saturation up, then down. The carried prediction is the model's.
    for (int i = 0; i < 3; i++) res(32'h40, 5'b01001, 1'b1, model_pred(32'h40), 32'h100);
    for (int i = 0; i < 4; i++) res(32'h40, 5'b01100, 1'b0, model_pred(32'h40), 32'h100);
    idle(32'h40, 1);
    chk("sat_low", {31'd0, pred_taken}, 32'd0);

    // JAL always redirects when predicted not-taken. Its entry is untouched.
    res(32'h10, 5'b11111, 1'b0, 1'b0, 32'h200);
    idle(32'h10, 1);
    chk("jal_entry", {31'd0, pred_taken}, 32'd0);
    // A non-branch predicted taken falls through, wrapping at the top of memory.
    res(32'hFFFF_FFFC, 5'b00000, 1'b1, 1'b1, 32'h1234);

    // A BNE arriving during FLUSH is wrong-path and must be ignored.
    drv(1'b1, 32'h44, 1'b1, 32'h44, 5'b01000, 1'b1, 1'b0, 32'h300);
    drv(1'b1, 32'h44, 1'b1, 32'h48, 5'b01001, 1'b1, 1'b0, 32'h400);
    idle(32'h48, FLUSH_CYC + 1);
    chk("ignored_train", {31'd0, pred_taken}, 32'd0);

    // Asynchronous reset in the first flush cycle.
    drv(1'b1, 32'h20, 1'b1, 32'h20, 5'b01110, 1'b1, 1'b0, 32'h500);
    rst_n = 1'b0;
    #1;
    chk("rstmid_flush", {31'd0, flush}, 32'd0);
    chk("rstmid_redirect", {31'd0, redirect}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(32'h40, 1);
    chk("rstmid_entry", {31'd0, pred_taken}, 32'd0);

    // Randomized traffic with aliasing PCs and occasional wrong predictions.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pcs[6];
      logic [31:0] pc, fpc;
      logic [4:0]  ops[8];
      logic [4:0]  op;
      logic        pt;
      pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h44; pcs[3] = 32'h10;
      pcs[4] = 32'hFFFF_FFFC; pcs[5] = $urandom & 32'hFFFF_FFFC;
      ops[0] = 5'b01000; ops[1] = 5'b01001; ops[2] = 5'b01100; ops[3] = 5'b01101;
      ops[4] = 5'b01110; ops[5] = 5'b01111; ops[6] = 5'b11111;
      ops[7] = 5'($urandom_range(0, 31));
      pc  = pcs[$urandom_range(0, 5)];
      fpc = pcs[$urandom_range(0, 5)];
      op  = ops[$urandom_range(0, 7)];
      pt  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'(model_pred(pc));
      drv(1'($urandom), fpc, ($urandom_range(0, 2) != 0), pc, op, 1'($urandom), pt,
          $urandom & 32'hFFFF_FFFC);
    end
    idle(32'h0, FLUSH_CYC + 2);
    chk("redirect_queue_empty", rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
